// File: rtl/fetch_ctrl_if.sv
// Bus bundle between the fetch sequencer and its environment: control pulses,
// the combinational ROM port, the decode-side handshake and the debug state.
//
// Handshake: out_valid/out_instr/out_pc are driven by fetch_ctrl; a transfer
// happens on a rising edge where out_valid & out_ready are both 1. While
// out_valid is 1 and out_ready is 0, out_instr and out_pc hold steady, and
// out_valid falls only after a transfer, a redirect, a start or a reset.
interface fetch_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              start;
  logic              halt;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              out_ready;
  logic [1:0]        state;

  // Environment side: drives control, ROM data and decode ready.
  modport master (
    output start, halt, redirect, redirect_pc, rom_data, out_ready,
    input  rom_addr, out_valid, out_instr, out_pc, state
  );

  // Sequencer side.
  modport slave (
    input  start, halt, redirect, redirect_pc, rom_data, out_ready,
    output rom_addr, out_valid, out_instr, out_pc, state
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses the combinational ROM,
// buffers {pc, instr} pairs in a small circular FIFO and presents the head to
// decode. Redirect and start flush the buffer; halt stops new fetches only.
module fetch_ctrl #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_HALTED = 2'b10
  } state_t;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_instr_mem [DEPTH];
  logic [ADDR_W-1:0] r_pc_mem    [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_valid;
  logic w_pop;
  logic w_space;
  logic w_flush;
  logic w_fetch;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full buffer still has room when its head leaves in the same cycle.
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & bus.out_ready;
  assign w_space = (r_count < CNT_W'(DEPTH)) | w_pop;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: start always wins; halt only matters while running.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.start)                            w_state_nxt = S_RUN;
    else if (bus.halt && (r_state == S_RUN))  w_state_nxt = S_HALTED;
  end

  // FSM outputs: flush on start/redirect, fetch only when running undisturbed.
  always_comb begin
    w_flush = bus.start | bus.redirect;
    w_fetch = 1'b0;
    if ((r_state == S_RUN) && !w_flush && !bus.halt && w_space) w_fetch = 1'b1;
  end

  // PC and buffer bookkeeping; a flush discards the head even if popped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_pc     <= bus.start ? RESET_PC : bus.redirect_pc;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_fetch) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
        r_pc     <= r_pc + 1'b1;
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_fetch, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Buffer storage; contents are only observed through the valid-gated head.
  always_ff @(posedge clk) begin
    if (w_fetch) begin
      r_instr_mem[r_wr_ptr] <= bus.rom_data;
      r_pc_mem[r_wr_ptr]    <= r_pc;
    end
  end

  assign bus.rom_addr  = r_pc;
  assign bus.out_valid = w_valid;
  assign bus.out_instr = w_valid ? r_instr_mem[r_rd_ptr] : '0;
  assign bus.out_pc    = w_valid ? r_pc_mem[r_rd_ptr]    : '0;
  assign bus.state     = r_state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by randomized control and
// backpressure, all compared each cycle with a queue-based behavioural model.
module tb_fetch_ctrl;

  localparam int DEPTH = 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  logic chk_en;

  fetch_ctrl_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  fetch_ctrl #(.ADDR_W(8), .DATA_W(16), .DEPTH(DEPTH), .RESET_PC(8'h00)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ROM ----------------
  function automatic logic [15:0] rom_fn(input logic [7:0] a);
    case (a)
      8'h00:   rom_fn = 16'hC000;
      8'h01:   rom_fn = 16'hC800;
      8'h02:   rom_fn = 16'hD002;
      8'h0D:   rom_fn = 16'h6C51;
      8'hFE:   rom_fn = 16'h0000;
      8'hFF:   rom_fn = 16'h9800;
      default: rom_fn = {a, ~a} ^ 16'h5A3C;
    endcase
  endfunction

  always_comb bus.rom_data = rom_fn(bus.rom_addr);

  // ---------------- reference model / scoreboard ----------------
  logic [23:0] exp_q[$];   // {pc, instr} fetched, not yet consumed
  logic [23:0] acc_q[$];   // {pc, instr} seen accepted by decode
  logic [1:0]  m_state;    // 0 idle, 1 run, 2 halted
  logic [7:0]  m_pc;

  always @(posedge clk) begin
    chk_en = 1'b1;
    if (!rst_n) begin
      m_state = 2'd0;
      m_pc    = 8'h00;
      exp_q.delete();
    end else if (bus.start) begin
      m_state = 2'd1;
      m_pc    = 8'h00;
      exp_q.delete();
    end else if (bus.redirect) begin
      exp_q.delete();
      m_pc = bus.redirect_pc;
      if (bus.halt && m_state == 2'd1) m_state = 2'd2;
    end else begin
      if (exp_q.size() > 0 && bus.out_ready) void'(exp_q.pop_front());
      if (m_state == 2'd1) begin
        if (bus.halt) m_state = 2'd2;
        else if (exp_q.size() < DEPTH) begin
          exp_q.push_back({m_pc, rom_fn(m_pc)});
          m_pc = m_pc + 8'd1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", {30'd0, bus.state}, {30'd0, m_state});
      chk("rom_addr", {24'd0, bus.rom_addr}, {24'd0, m_pc});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0)
        chk("head", {8'd0, bus.out_pc, bus.out_instr}, {8'd0, exp_q[0]});
      if (bus.out_valid && bus.out_ready) acc_q.push_back({bus.out_pc, bus.out_instr});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    acc_q.delete();
  endtask

  task automatic pulse_redirect(input logic [7:0] pc);
    bus.redirect    = 1'b1;
    bus.redirect_pc = pc;
    step();
    bus.redirect = 1'b0;
  endtask

  task automatic chk_acc(input string tag, input int idx, input logic [23:0] exp);
    logic [23:0] got;
    got = (idx < acc_q.size()) ? acc_q[idx] : 24'hxxxxxx;
    chk(tag, {8'd0, got}, {8'd0, exp});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    chk_en   = 1'b0;
    rst_n    = 1'b0;
    bus.start = 1'b0;
    bus.halt = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 8'h00;
    bus.out_ready = 1'b1;
    step(3);
    @(negedge clk);
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_state", {30'd0, bus.state}, 32'd0);
    chk("rst_instr", {16'd0, bus.out_instr}, 32'd0);
    chk("rst_pc", {24'd0, bus.out_pc}, 32'd0);
    rst_n = 1'b1;
    step();

    // Back-to-back streaming from reset PC.
    bus.out_ready = 1'b1;
    step();
    pulse_start();
    step(6);
    chk_acc("s1_a0", 0, {8'h00, 16'hC000});
    chk_acc("s1_a1", 1, {8'h01, 16'hC800});
    chk_acc("s1_a2", 2, {8'h02, 16'hD002});

    // Backpressure fills the buffer, then drains in order.
    bus.out_ready = 1'b0;
    pulse_start();
    step(5);
    @(negedge clk);
    chk("s2_rom_addr", {24'd0, bus.rom_addr}, 32'h02);
    chk("s2_head_pc", {24'd0, bus.out_pc}, 32'h00);
    chk("s2_head_instr", {16'd0, bus.out_instr}, 32'hC000);
    step();
    bus.out_ready = 1'b1;
    step(4);
    chk_acc("s2_a0", 0, {8'h00, 16'hC000});
    chk_acc("s2_a1", 1, {8'h01, 16'hC800});
    chk_acc("s2_a2", 2, {8'h02, 16'hD002});

    // Redirect with entries pending: stale words never reach decode.
    bus.out_ready = 1'b0;
    pulse_start();
    step(3);
    pulse_redirect(8'h0D);
    acc_q.delete();
    bus.out_ready = 1'b1;
    step(4);
    chk_acc("s3_a0", 0, {8'h0D, 16'h6C51});
    chk_acc("s3_a1", 1, {8'h0E, rom_fn(8'h0E)});

    // PC wrap.
    pulse_redirect(8'hFE);
    acc_q.delete();
    step(5);
    chk_acc("s4_a0", 0, {8'hFE, 16'h0000});
    chk_acc("s4_a1", 1, {8'hFF, 16'h9800});
    chk_acc("s4_a2", 2, {8'h00, 16'hC000});

    // Halt after three fetches; buffer drains, PC freezes; start refetches.
    pulse_start();
    step(3);
    bus.halt = 1'b1;
    step();
    bus.halt = 1'b0;
    step(4);
    @(negedge clk);
    chk("s5_n_acc", acc_q.size(), 32'd3);
    chk_acc("s5_a2", 2, {8'h02, 16'hD002});
    chk("s5_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("s5_state", {30'd0, bus.state}, 32'h2);
    chk("s5_rom_addr", {24'd0, bus.rom_addr}, 32'h03);
    step();
    pulse_start();
    step(4);
    chk_acc("s5_restart", 0, {8'h00, 16'hC000});

    // Reset with a full buffer.
    bus.out_ready = 1'b0;
    pulse_start();
    step(4);
    @(negedge clk);
    chk("s6_full_valid", {31'd0, bus.out_valid}, 32'd1);
    step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("s6_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("s6_state", {30'd0, bus.state}, 32'd0);
    chk("s6_rom_addr", {24'd0, bus.rom_addr}, 32'd0);
    chk("s6_instr", {16'd0, bus.out_instr}, 32'd0);
    step();
    rst_n = 1'b1;

    // Randomized control, redirects and backpressure.
    for (int i = 0; i < 3000; i++) begin
      bus.start       = ($urandom_range(0, 49) == 0);
      bus.halt        = ($urandom_range(0, 29) == 0);
      bus.redirect    = ($urandom_range(0, 14) == 0);
      bus.redirect_pc = 8'($urandom_range(0, 255));
      bus.out_ready   = ($urandom_range(0, 9) < 7);
      rst_n           = ($urandom_range(0, 299) != 0);
      if (i % 400 == 0) bus.start = 1'b1;
      step();
    end
    bus.start = 1'b0;
    bus.halt = 1'b0;
    bus.redirect = 1'b0;
    rst_n = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
